// File: rtl/rotor_bank_fwd_pkg.sv
// Shared definitions for the three-rotor forward pass: letter codes, rotor
// wirings, notch positions and the mod-26 helpers used by every stage.
package rotor_bank_fwd_pkg;

    localparam logic [4:0] LETTER_LIMIT = 5'd26;

    localparam logic [4:0] L_A = 5'd0;
    localparam logic [4:0] L_B = 5'd1;
    localparam logic [4:0] L_C = 5'd2;
    localparam logic [4:0] L_D = 5'd3;
    localparam logic [4:0] L_E = 5'd4;
    localparam logic [4:0] L_F = 5'd5;
    localparam logic [4:0] L_G = 5'd6;
    localparam logic [4:0] L_H = 5'd7;
    localparam logic [4:0] L_I = 5'd8;
    localparam logic [4:0] L_J = 5'd9;
    localparam logic [4:0] L_K = 5'd10;
    localparam logic [4:0] L_L = 5'd11;
    localparam logic [4:0] L_M = 5'd12;
    localparam logic [4:0] L_N = 5'd13;
    localparam logic [4:0] L_O = 5'd14;
    localparam logic [4:0] L_P = 5'd15;
    localparam logic [4:0] L_Q = 5'd16;
    localparam logic [4:0] L_R = 5'd17;
    localparam logic [4:0] L_S = 5'd18;
    localparam logic [4:0] L_T = 5'd19;
    localparam logic [4:0] L_U = 5'd20;
    localparam logic [4:0] L_V = 5'd21;
    localparam logic [4:0] L_W = 5'd22;
    localparam logic [4:0] L_X = 5'd23;
    localparam logic [4:0] L_Y = 5'd24;
    localparam logic [4:0] L_Z = 5'd25;

    typedef enum logic [1:0] {
        ROTOR_I   = 2'd0,
        ROTOR_II  = 2'd1,
        ROTOR_III = 2'd2
    } rotor_id_e;

    typedef struct packed {
        logic [4:0] l;
        logic [4:0] m;
        logic [4:0] r;
    } rotor_pos_t;

    localparam logic [4:0] WIRING_I [0:25] = '{
        L_E, L_K, L_M, L_F, L_L, L_G, L_D, L_Q, L_V, L_Z, L_N, L_T, L_O,
        L_W, L_Y, L_H, L_X, L_U, L_S, L_P, L_A, L_I, L_B, L_R, L_C, L_J};
    localparam logic [4:0] WIRING_II [0:25] = '{
        L_A, L_J, L_D, L_K, L_S, L_I, L_R, L_U, L_X, L_B, L_L, L_H, L_W,
        L_T, L_M, L_C, L_Q, L_G, L_Z, L_N, L_P, L_Y, L_F, L_V, L_O, L_E};
    localparam logic [4:0] WIRING_III [0:25] = '{
        L_B, L_D, L_F, L_H, L_J, L_L, L_C, L_P, L_R, L_T, L_X, L_V, L_Z,
        L_N, L_O, L_Y, L_E, L_Q, L_I, L_U, L_W, L_G, L_S, L_M, L_K, L_A};

    localparam logic [4:0] NOTCH_I   = L_Q;
    localparam logic [4:0] NOTCH_II  = L_E;
    localparam logic [4:0] NOTCH_III = L_V;

    // (a + b) mod 26 for operands already in 0..25
    function automatic logic [4:0] mod26_add(input logic [4:0] a, input logic [4:0] b);
        logic [5:0] sum;
        logic [5:0] res;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= 6'd26) begin
            res = sum - 6'd26;
        end else begin
            res = sum;
        end
        return res[4:0];
    endfunction

    // (a - b) mod 26 for operands already in 0..25
    function automatic logic [4:0] mod26_sub(input logic [4:0] a, input logic [4:0] b);
        logic [5:0] diff;
        if (a >= b) begin
            diff = {1'b0, a} - {1'b0, b};
        end else begin
            diff = {1'b0, a} + 6'd26 - {1'b0, b};
        end
        return diff[4:0];
    endfunction

    // Fold a raw 5-bit value (0..31) into 0..25
    function automatic logic [4:0] mod26_reduce(input logic [4:0] v);
        logic [4:0] res;
        if (v >= LETTER_LIMIT) begin
            res = v - LETTER_LIMIT;
        end else begin
            res = v;
        end
        return res;
    endfunction

    // Contact lookup; out-of-range indices map to A so no table is over-read
    function automatic logic [4:0] wiring_lookup(input rotor_id_e id, input logic [4:0] idx);
        logic [4:0] w;
        w = L_A;
        if (idx < LETTER_LIMIT) begin
            case (id)
                ROTOR_I:   w = WIRING_I[idx];
                ROTOR_II:  w = WIRING_II[idx];
                ROTOR_III: w = WIRING_III[idx];
                default:   w = L_A;
            endcase
        end else begin
            w = L_A;
        end
        return w;
    endfunction

endpackage

// File: rtl/rotor_bank_fwd_if.sv
// Letter, configuration and result signals between the plaintext source,
// the rotor bank and the reflector stage.
interface rotor_bank_fwd_if;
    logic       cfg_load;
    logic [4:0] cfg_pos_l;
    logic [4:0] cfg_pos_m;
    logic [4:0] cfg_pos_r;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_letter;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_letter;
    logic [4:0] out_pos_l;
    logic [4:0] out_pos_m;
    logic [4:0] out_pos_r;
    logic       in_err;

    modport master (
        output cfg_load, cfg_pos_l, cfg_pos_m, cfg_pos_r,
        output in_valid, in_letter, out_ready,
        input  in_ready, out_valid, out_letter,
        input  out_pos_l, out_pos_m, out_pos_r, in_err
    );

    modport slave (
        input  cfg_load, cfg_pos_l, cfg_pos_m, cfg_pos_r,
        input  in_valid, in_letter, out_ready,
        output in_ready, out_valid, out_letter,
        output out_pos_l, out_pos_m, out_pos_r, in_err
    );
endinterface

// File: rtl/rotor_fwd_map.sv
// Forward substitution through one rotor at a given position:
// out = (W[(in + p) mod 26] - p) mod 26.
module rotor_fwd_map
    import rotor_bank_fwd_pkg::*;
(
    input  logic [4:0] letter_in,
    input  logic [4:0] position,
    input  rotor_id_e  rotor_id,
    output logic [4:0] letter_out
);

    logic [4:0] contact_s;
    logic [4:0] wired_s;

    // Offset into the wiring, look up, then undo the offset
    always_comb begin
        contact_s  = mod26_add(letter_in, position);
        wired_s    = wiring_lookup(rotor_id, contact_s);
        letter_out = mod26_sub(wired_s, position);
    end

endmodule

// File: rtl/rotor_bank_fwd.sv
// Forward pass through rotors III (right), II (middle), I (left) as a
// 3-stage pipeline with Enigma double-step position logic.
module rotor_bank_fwd
    import rotor_bank_fwd_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    rotor_bank_fwd_if.slave bus
);

    rotor_pos_t pos_d, pos_q, pos_step_s, pos_cfg_s;
    logic       advance_s, in_ready_s, accept_s, letter_ok_s, step_s;
    logic       pipe_empty_s, load_s;

    logic       s1_valid_d, s1_valid_q, s2_valid_d, s2_valid_q;
    logic       out_valid_d, out_valid_q, in_err_d, in_err_q;
    logic [4:0] s1_letter_d, s1_letter_q, s2_letter_d, s2_letter_q;
    logic [4:0] out_letter_d, out_letter_q;
    rotor_pos_t s1_pos_d, s1_pos_q, s2_pos_d, s2_pos_q, out_pos_d, out_pos_q;
    logic [4:0] right_out_s, mid_out_s, left_out_s;

    rotor_fwd_map u_right (
        .letter_in  (bus.in_letter),
        .position   (pos_step_s.r),
        .rotor_id   (ROTOR_III),
        .letter_out (right_out_s)
    );

    rotor_fwd_map u_mid (
        .letter_in  (s1_letter_q),
        .position   (s1_pos_q.m),
        .rotor_id   (ROTOR_II),
        .letter_out (mid_out_s)
    );

    rotor_fwd_map u_left (
        .letter_in  (s2_letter_q),
        .position   (s2_pos_q.l),
        .rotor_id   (ROTOR_I),
        .letter_out (left_out_s)
    );

    // Handshake: one global advance; a pending load blocks letter acceptance
    always_comb begin
        advance_s    = ~out_valid_q | bus.out_ready;
        in_ready_s   = advance_s & ~bus.cfg_load & ~reset;
        accept_s     = bus.in_valid & in_ready_s;
        letter_ok_s  = (bus.in_letter < LETTER_LIMIT);
        step_s       = accept_s & letter_ok_s;
        pipe_empty_s = ~s1_valid_q & ~s2_valid_q & ~out_valid_q;
        load_s       = bus.cfg_load & pipe_empty_s;
        in_err_d     = accept_s & ~letter_ok_s;
    end

    // Position update: load, or step with double-step decided on pre-step values
    always_comb begin
        pos_step_s.r = mod26_add(pos_q.r, 5'd1);
        if ((pos_q.r == NOTCH_III) || (pos_q.m == NOTCH_II)) begin
            pos_step_s.m = mod26_add(pos_q.m, 5'd1);
        end else begin
            pos_step_s.m = pos_q.m;
        end
        if (pos_q.m == NOTCH_II) begin
            pos_step_s.l = mod26_add(pos_q.l, 5'd1);
        end else begin
            pos_step_s.l = pos_q.l;
        end
        pos_cfg_s.l = mod26_reduce(bus.cfg_pos_l);
        pos_cfg_s.m = mod26_reduce(bus.cfg_pos_m);
        pos_cfg_s.r = mod26_reduce(bus.cfg_pos_r);
        if (load_s) begin
            pos_d = pos_cfg_s;
        end else if (step_s) begin
            pos_d = pos_step_s;
        end else begin
            pos_d = pos_q;
        end
    end

    // Pipeline shift on advance, otherwise every stage holds
    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_letter_d  = s1_letter_q;
        s1_pos_d     = s1_pos_q;
        s2_valid_d   = s2_valid_q;
        s2_letter_d  = s2_letter_q;
        s2_pos_d     = s2_pos_q;
        out_valid_d  = out_valid_q;
        out_letter_d = out_letter_q;
        out_pos_d    = out_pos_q;
        if (advance_s) begin
            s1_valid_d   = step_s;
            s1_letter_d  = right_out_s;
            s1_pos_d     = pos_step_s;
            s2_valid_d   = s1_valid_q;
            s2_letter_d  = mid_out_s;
            s2_pos_d     = s1_pos_q;
            out_valid_d  = s2_valid_q;
            out_letter_d = left_out_s;
            out_pos_d    = s2_pos_q;
        end else begin
            out_valid_d  = out_valid_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            pos_q        <= '0;
            s1_valid_q   <= 1'b0;
            s1_letter_q  <= 5'd0;
            s1_pos_q     <= '0;
            s2_valid_q   <= 1'b0;
            s2_letter_q  <= 5'd0;
            s2_pos_q     <= '0;
            out_valid_q  <= 1'b0;
            out_letter_q <= 5'd0;
            out_pos_q    <= '0;
            in_err_q     <= 1'b0;
        end else begin
            pos_q        <= pos_d;
            s1_valid_q   <= s1_valid_d;
            s1_letter_q  <= s1_letter_d;
            s1_pos_q     <= s1_pos_d;
            s2_valid_q   <= s2_valid_d;
            s2_letter_q  <= s2_letter_d;
            s2_pos_q     <= s2_pos_d;
            out_valid_q  <= out_valid_d;
            out_letter_q <= out_letter_d;
            out_pos_q    <= out_pos_d;
            in_err_q     <= in_err_d;
        end
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_letter = out_letter_q;
    assign bus.out_pos_l  = out_pos_q.l;
    assign bus.out_pos_m  = out_pos_q.m;
    assign bus.out_pos_r  = out_pos_q.r;
    assign bus.in_err     = in_err_q;

endmodule

// File: tb/tb_rotor_bank_fwd.sv
// Scoreboard bench for rotor_bank_fwd: a string-table Enigma model predicts
// each accepted letter; results are popped when the DUT hands them over.
module tb_rotor_bank_fwd;

    typedef struct {
        int letter;
        int pl;
        int pm;
        int pr;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rotor_bank_fwd_if bus();

    rotor_bank_fwd dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad = 0;
    int n_out = 0;
    int ml, mm, mr;
    exp_t sbq[$];
    logic err_pend;
    logic stalled_prev;
    logic last_acc;
    logic [4:0] held_letter, held_l, held_m, held_r;

    string w_rot1 = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
    string w_rot2 = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
    string w_rot3 = "BDFHJLCPRTXVZNOYEQIUWGSMKA";

    function automatic int rot(string w, int x, int p);
        int c;
        c = int'(w[(x + p) % 26]) - 65;
        return ((c - p) % 26 + 26) % 26;
    endfunction

    // Drive one cycle at the falling edge, predict, and check the DUT
    task automatic drive_cycle(input logic v, input logic [4:0] letter, input logic ordy, input logic load);
        exp_t e;
        logic exp_rdy;
        int x;
        @(negedge clk);
        bus.in_valid = v;
        bus.in_letter = letter;
        bus.out_ready = ordy;
        bus.cfg_load = load;
        #1;
        total++;
        if (bus.in_err !== err_pend) begin
            bad++;
            $display("FAIL in_err got=%0b exp=%0b", bus.in_err, err_pend);
        end
        if (stalled_prev) begin
            total++;
            if ({bus.out_letter, bus.out_pos_l, bus.out_pos_m, bus.out_pos_r} !==
                {held_letter, held_l, held_m, held_r}) begin
                bad++;
                $display("FAIL stall_hold got=%0d/%0d,%0d,%0d exp=%0d/%0d,%0d,%0d",
                         bus.out_letter, bus.out_pos_l, bus.out_pos_m, bus.out_pos_r,
                         held_letter, held_l, held_m, held_r);
            end
        end
        exp_rdy = (!bus.out_valid | ordy) & !load;
        total++;
        if (bus.in_ready !== exp_rdy) begin
            bad++;
            $display("FAIL in_ready got=%0b exp=%0b", bus.in_ready, exp_rdy);
        end
        err_pend = 1'b0;
        last_acc = 1'b0;
        if (load && sbq.size() == 0) begin
            ml = int'(bus.cfg_pos_l) % 26;
            mm = int'(bus.cfg_pos_m) % 26;
            mr = int'(bus.cfg_pos_r) % 26;
        end
        if (v && exp_rdy) begin
            last_acc = 1'b1;
            if (letter < 5'd26) begin
                if (mm == 4) begin
                    ml = (ml + 1) % 26;
                    mm = (mm + 1) % 26;
                end else if (mr == 21) begin
                    mm = (mm + 1) % 26;
                end
                mr = (mr + 1) % 26;
                x = rot(w_rot3, int'(letter), mr);
                x = rot(w_rot2, x, mm);
                x = rot(w_rot1, x, ml);
                e.letter = x;
                e.pl = ml;
                e.pm = mm;
                e.pr = mr;
                sbq.push_back(e);
            end else begin
                err_pend = 1'b1;
            end
        end
        if (bus.out_valid && ordy) begin
            n_out++;
            total++;
            if (sbq.size() == 0) begin
                bad++;
                $display("FAIL spurious_out got=%0d exp=none", bus.out_letter);
            end else begin
                e = sbq.pop_front();
                if ({bus.out_letter, bus.out_pos_l, bus.out_pos_m, bus.out_pos_r} !==
                    {5'(e.letter), 5'(e.pl), 5'(e.pm), 5'(e.pr)}) begin
                    bad++;
                    $display("FAIL out_data got=%0d/%0d,%0d,%0d exp=%0d/%0d,%0d,%0d",
                             bus.out_letter, bus.out_pos_l, bus.out_pos_m, bus.out_pos_r,
                             e.letter, e.pl, e.pm, e.pr);
                end
            end
        end
        stalled_prev = bus.out_valid & !ordy;
        held_letter = bus.out_letter;
        held_l = bus.out_pos_l;
        held_m = bus.out_pos_m;
        held_r = bus.out_pos_r;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_letter = 5'd2;
        bus.out_ready = 1'b1;
        bus.cfg_load = 1'b0;
        #1;
        total++;
        if (bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL rst_in_ready got=%0b exp=0", bus.in_ready);
        end
        @(negedge clk);
        #1;
        total++;
        if ({bus.out_valid, bus.out_letter, bus.out_pos_l, bus.out_pos_m, bus.out_pos_r, bus.in_err} !== 22'd0) begin
            bad++;
            $display("FAIL rst_outputs got=%0b/%0d/%0d,%0d,%0d/%0b exp=0",
                     bus.out_valid, bus.out_letter, bus.out_pos_l, bus.out_pos_m, bus.out_pos_r, bus.in_err);
        end
        reset = 1'b0;
        bus.in_valid = 1'b0;
        sbq.delete();
        ml = 0;
        mm = 0;
        mr = 0;
        err_pend = 1'b0;
        stalled_prev = 1'b0;
    endtask

    task automatic check_out(input string name, input logic v, input int l, input int pl, input int pm, input int pr);
        total++;
        if ({bus.out_valid, bus.out_letter, bus.out_pos_l, bus.out_pos_m, bus.out_pos_r} !==
            {v, 5'(l), 5'(pl), 5'(pm), 5'(pr)}) begin
            bad++;
            $display("FAIL %s got=%0b/%0d/%0d,%0d,%0d exp=%0b/%0d/%0d,%0d,%0d", name,
                     bus.out_valid, bus.out_letter, bus.out_pos_l, bus.out_pos_m, bus.out_pos_r,
                     v, l, pl, pm, pr);
        end
    endtask

    task automatic test_reset();
        do_reset();
        drive_cycle(1'b0, 5'd0, 1'b1, 1'b0);
    endtask

    task automatic test_basic();
        drive_cycle(1'b1, 5'd0, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            drive_cycle(1'b0, 5'd0, 1'b1, 1'b0);
            total++;
            if (bus.out_valid !== 1'b0) begin
                bad++;
                $display("FAIL latency_early got=%0b exp=0 cycle=%0d", bus.out_valid, i + 1);
            end
        end
        drive_cycle(1'b0, 5'd0, 1'b1, 1'b0);
        check_out("basic_A", 1'b1, 5, 0, 0, 1);
    endtask

    task automatic test_double_step();
        bus.cfg_pos_l = 5'd0;
        bus.cfg_pos_m = 5'd3;
        bus.cfg_pos_r = 5'd20;
        drive_cycle(1'b1, 5'd4, 1'b1, 1'b1);
        drive_cycle(1'b1, 5'd7, 1'b1, 1'b0);
        drive_cycle(1'b1, 5'd11, 1'b1, 1'b0);
        drive_cycle(1'b1, 5'd19, 1'b1, 1'b0);
        drive_cycle(1'b0, 5'd0, 1'b1, 1'b0);
        check_out("dstep_pos1", 1'b1, rot(w_rot1, rot(w_rot2, rot(w_rot3, 7, 21), 3), 0), 0, 3, 21);
        drive_cycle(1'b0, 5'd0, 1'b1, 1'b0);
        check_out("dstep_pos2", 1'b1, rot(w_rot1, rot(w_rot2, rot(w_rot3, 11, 22), 4), 0), 0, 4, 22);
        drive_cycle(1'b0, 5'd0, 1'b1, 1'b0);
        check_out("dstep_pos3", 1'b1, rot(w_rot1, rot(w_rot2, rot(w_rot3, 19, 23), 5), 1), 1, 5, 23);
    endtask

    task automatic test_wrap();
        bus.cfg_pos_l = 5'd25;
        bus.cfg_pos_m = 5'd4;
        bus.cfg_pos_r = 5'd25;
        drive_cycle(1'b0, 5'd0, 1'b1, 1'b1);
        drive_cycle(1'b1, 5'd13, 1'b1, 1'b0);
        drive_cycle(1'b0, 5'd0, 1'b1, 1'b0);
        drive_cycle(1'b0, 5'd0, 1'b1, 1'b0);
        drive_cycle(1'b0, 5'd0, 1'b1, 1'b0);
        check_out("wrap_pos", 1'b1, rot(w_rot1, rot(w_rot2, rot(w_rot3, 13, 0), 5), 0), 0, 5, 0);
        bus.cfg_pos_l = 5'd31;
        bus.cfg_pos_m = 5'd30;
        bus.cfg_pos_r = 5'd26;
        drive_cycle(1'b0, 5'd0, 1'b1, 1'b1);
        drive_cycle(1'b1, 5'd25, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 5'd0, 1'b1, 1'b0);
        check_out("cfg_reduce", 1'b1, rot(w_rot1, rot(w_rot2, rot(w_rot3, 25, 1), 5), 6), 6, 5, 1);
    endtask

    task automatic test_stream();
        int sent = 0;
        int cyc = 0;
        int out0;
        out0 = n_out;
        while (sent < 10 && cyc < 200) begin
            drive_cycle(1'b1, 5'((sent * 7 + 3) % 26), 1'((cyc % 2) == 0), 1'b0);
            if (last_acc) sent++;
            cyc++;
        end
        cyc = 0;
        while (sbq.size() > 0 && cyc < 50) begin
            drive_cycle(1'b0, 5'd0, 1'((cyc % 2) == 1), 1'b0);
            cyc++;
        end
        total++;
        if (sent != 10 || sbq.size() != 0 || (n_out - out0) != 10) begin
            bad++;
            $display("FAIL stream_count got=sent%0d/out%0d/left%0d exp=10/10/0", sent, n_out - out0, sbq.size());
        end
    endtask

    task automatic test_err_and_cfg_ignore();
        drive_cycle(1'b1, 5'd27, 1'b1, 1'b0);
        drive_cycle(1'b0, 5'd0, 1'b1, 1'b0);
        total++;
        if (bus.in_err !== 1'b1) begin
            bad++;
            $display("FAIL err_pulse got=%0b exp=1", bus.in_err);
        end
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 5'd0, 1'b1, 1'b0);
            total++;
            if (bus.out_valid !== 1'b0 || bus.in_err !== 1'b0) begin
                bad++;
                $display("FAIL err_no_out got=%0b/%0b exp=0/0", bus.out_valid, bus.in_err);
            end
        end
        bus.cfg_pos_l = 5'd7;
        bus.cfg_pos_m = 5'd7;
        bus.cfg_pos_r = 5'd7;
        drive_cycle(1'b1, 5'd1, 1'b1, 1'b0);
        drive_cycle(1'b1, 5'd2, 1'b1, 1'b0);
        drive_cycle(1'b1, 5'd3, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 5'd0, 1'b1, 1'b0);
        drive_cycle(1'b1, 5'd9, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 5'd0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_in_flight();
        drive_cycle(1'b1, 5'd5, 1'b1, 1'b0);
        drive_cycle(1'b1, 5'd6, 1'b1, 1'b0);
        drive_cycle(1'b1, 5'd8, 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b0, 5'd0, 1'b1, 1'b0);
            total++;
            if (bus.out_valid !== 1'b0) begin
                bad++;
                $display("FAIL flushed_out got=%0b exp=0", bus.out_valid);
            end
        end
        drive_cycle(1'b1, 5'd0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 5'd0, 1'b1, 1'b0);
        check_out("post_reset_A", 1'b1, 5, 0, 0, 1);
    endtask

    initial begin
        reset = 1'b1;
        bus.cfg_load = 1'b0;
        bus.cfg_pos_l = 5'd0;
        bus.cfg_pos_m = 5'd0;
        bus.cfg_pos_r = 5'd0;
        bus.in_valid = 1'b0;
        bus.in_letter = 5'd0;
        bus.out_ready = 1'b1;
        ml = 0;
        mm = 0;
        mr = 0;
        err_pend = 1'b0;
        stalled_prev = 1'b0;
        last_acc = 1'b0;
        test_reset();
        test_basic();
        test_double_step();
        test_wrap();
        test_stream();
        test_err_and_cfg_ignore();
        test_reset_in_flight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
